// File: rtl/vga_sync_if.sv
// Raster/sync bundle from vga_sync to the pixel-colour logic and VGA pins.
interface vga_sync_if;
  logic        p_tick;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (output p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_start, frame_count);
  modport slave  (input  p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_start, frame_count);
endinterface

// File: rtl/vga_sync.sv
// Raster timing generator: pixel-rate enable, x/y counters, registered sync/blank decode.
// Optional frame counter built only when VGA_FRAME_CNT_EN is defined.
module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0]    H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_DISP = 10'(H_DISPLAY);
  localparam logic [9:0]    V_DISP = 10'(V_DISPLAY);
  localparam logic [9:0]    HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]    HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]    VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]    VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] d;
  logic [9:0]    x, y, nx, ny;
  logic          tick, wrap;
  logic          video_on_q, hsync_q, vsync_q, frame_start_q;

  assign tick = (d == D_LAST) && !reset;
  assign wrap = (x == H_LAST) && (y == V_LAST);

  always_comb begin
    nx = x + 10'd1;
    ny = y;
    if (x == H_LAST) begin
      nx = '0;
      ny = (y == V_LAST) ? '0 : y + 10'd1;
    end
  end

  // Decode from next counter values so the registered flags line up with pix_x/pix_y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d             <= '0;
      x             <= H_LAST;
      y             <= V_LAST;
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      d             <= (d == D_LAST) ? '0 : d + DW'(1);
      frame_start_q <= tick && wrap;
      if (tick) begin
        x          <= nx;
        y          <= ny;
        video_on_q <= (nx < H_DISP) && (ny < V_DISP);
        hsync_q    <= (nx >= HS_BEG && nx <= HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_q    <= (ny >= VS_BEG && ny <= VS_END) ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              fcnt <= '0;
    else if (tick && wrap)  fcnt <= fcnt + 16'd1;
  end

  assign vga.frame_count = fcnt;
`else
  assign vga.frame_count = 16'd0;
`endif

  assign vga.p_tick      = tick;
  assign vga.pix_x       = x;
  assign vga.pix_y       = y;
  assign vga.video_on    = video_on_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: default 640x480 timing plus two shrunk 10x5 rasters.
module tb_vga_sync;
  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  always #5 clk = ~clk;

  vga_sync_if ia ();
  vga_sync_if ib ();
  vga_sync_if ic ();

  vga_sync dut_a (.clk(clk), .reset(rst_a), .vga(ia));
  vga_sync #(.H_DISPLAY(7), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
             .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
             .CLK_DIV(1), .SYNC_POL(1'b0)) dut_b (.clk(clk), .reset(rst_b), .vga(ib));
  vga_sync #(.H_DISPLAY(7), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
             .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
             .CLK_DIV(4), .SYNC_POL(1'b0)) dut_c (.clk(clk), .reset(rst_c), .vga(ic));

  typedef struct {
    int   k;
    logic pt;
    int   x;
    int   y;
    logic von;
    logic hs;
    logic vs;
    logic fs;
    int   fc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic int fce(int n);
`ifdef VGA_FRAME_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  function automatic vec_t mk(int k, logic pt, int x, int y, logic von, logic hs,
                              logic vs, logic fs, int fc);
    vec_t v;
    v.k = k; v.pt = pt; v.x = x; v.y = y; v.von = von;
    v.hs = hs; v.vs = vs; v.fs = fs; v.fc = fc;
    return v;
  endfunction

  function automatic vec_t snap_a();
    return mk(0, ia.p_tick, int'(ia.pix_x), int'(ia.pix_y), ia.video_on, ia.hsync,
              ia.vsync, ia.frame_start, int'(ia.frame_count));
  endfunction

  function automatic vec_t snap_b();
    return mk(0, ib.p_tick, int'(ib.pix_x), int'(ib.pix_y), ib.video_on, ib.hsync,
              ib.vsync, ib.frame_start, int'(ib.frame_count));
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp(string tag, vec_t e, vec_t a);
    string p;
    p = $sformatf("%s k=%0d", tag, e.k);
    chk({p, " p_tick"},      int'(a.pt),  int'(e.pt));
    chk({p, " pix_x"},       a.x,         e.x);
    chk({p, " pix_y"},       a.y,         e.y);
    chk({p, " video_on"},    int'(a.von), int'(e.von));
    chk({p, " hsync"},       int'(a.hs),  int'(e.hs));
    chk({p, " vsync"},       int'(a.vs),  int'(e.vs));
    chk({p, " frame_start"}, int'(a.fs),  int'(e.fs));
    chk({p, " frame_count"}, a.fc,        e.fc);
  endtask

  initial begin
    vec_t ta[$];
    vec_t tb[$];
    vec_t rst_a_vec;
    int ka, kb, kc, hs_low, vs_low, fs_n, fs1, fs2;

    rst_a_vec = mk(0, 0, 799, 524, 0, 1, 1, 0, 0);

    // k = clk edges since reset release; pixel p = k/CLK_DIV - 1 in raster order
    ta.push_back(mk(0,    0, 799, 524, 0, 1, 1, 0, 0));
    ta.push_back(mk(3,    1, 799, 524, 0, 1, 1, 0, 0));
    ta.push_back(mk(4,    0, 0,   0,   1, 1, 1, 1, fce(1)));
    ta.push_back(mk(5,    0, 0,   0,   1, 1, 1, 0, fce(1)));
    ta.push_back(mk(7,    1, 0,   0,   1, 1, 1, 0, fce(1)));
    ta.push_back(mk(8,    0, 1,   0,   1, 1, 1, 0, fce(1)));
    ta.push_back(mk(2563, 1, 639, 0,   1, 1, 1, 0, fce(1)));
    ta.push_back(mk(2564, 0, 640, 0,   0, 1, 1, 0, fce(1)));
    ta.push_back(mk(2627, 1, 655, 0,   0, 1, 1, 0, fce(1)));
    ta.push_back(mk(2628, 0, 656, 0,   0, 0, 1, 0, fce(1)));
    ta.push_back(mk(3011, 1, 751, 0,   0, 0, 1, 0, fce(1)));
    ta.push_back(mk(3012, 0, 752, 0,   0, 1, 1, 0, fce(1)));
    ta.push_back(mk(3203, 1, 799, 0,   0, 1, 1, 0, fce(1)));
    ta.push_back(mk(3204, 0, 0,   1,   1, 1, 1, 0, fce(1)));

    tb.push_back(mk(0,   1, 9, 4, 0, 1, 1, 0, 0));
    tb.push_back(mk(1,   1, 0, 0, 1, 1, 1, 1, fce(1)));
    tb.push_back(mk(2,   1, 1, 0, 1, 1, 1, 0, fce(1)));
    tb.push_back(mk(8,   1, 7, 0, 0, 1, 1, 0, fce(1)));
    tb.push_back(mk(9,   1, 8, 0, 0, 0, 1, 0, fce(1)));
    tb.push_back(mk(10,  1, 9, 0, 0, 1, 1, 0, fce(1)));
    tb.push_back(mk(11,  1, 0, 1, 1, 1, 1, 0, fce(1)));
    tb.push_back(mk(31,  1, 0, 3, 0, 1, 0, 0, fce(1)));
    tb.push_back(mk(40,  1, 9, 3, 0, 1, 0, 0, fce(1)));
    tb.push_back(mk(41,  1, 0, 4, 0, 1, 1, 0, fce(1)));
    tb.push_back(mk(50,  1, 9, 4, 0, 1, 1, 0, fce(1)));
    tb.push_back(mk(51,  1, 0, 0, 1, 1, 1, 1, fce(2)));
    tb.push_back(mk(52,  1, 1, 0, 1, 1, 1, 0, fce(2)));
    tb.push_back(mk(101, 1, 0, 0, 1, 1, 1, 1, fce(3)));

    // T1: held in reset; p_tick must stay low even with CLK_DIV=1
    repeat (3) @(posedge clk);
    #1;
    cmp("T1 A", rst_a_vec, snap_a());
    cmp("T1 B", mk(0, 0, 9, 4, 0, 1, 1, 0, 0), snap_b());

    // T2/T3: release and walk one full line at default timing
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    ka = 0;
    hs_low = 0;
    foreach (ta[i]) begin
      while (ka < ta[i].k) begin
        @(posedge clk); #1; ka++;
        if (!ia.hsync) hs_low++;
      end
      cmp("A", ta[i], snap_a());
    end
    chk("T3 hsync low clk", hs_low, 384);

    // T5: async reset between edges at pixel (300,1), then T2 timing again
    while (ka < 4405) begin
      @(posedge clk); #1; ka++;
    end
    chk("T5 pre pix_x", int'(ia.pix_x), 300);
    #2;
    rst_a = 1'b1;
    #1;
    cmp("T5 async", rst_a_vec, snap_a());
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    ka = 0;
    for (int i = 0; i < 6; i++) begin
      while (ka < ta[i].k) begin
        @(posedge clk); #1; ka++;
      end
      cmp("T5 rerun", ta[i], snap_a());
    end

    // T6: shrunk raster, CLK_DIV=1
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    kb = 0;
    foreach (tb[i]) begin
      while (kb < tb[i].k) begin
        @(posedge clk); #1; kb++;
      end
      cmp("B", tb[i], snap_b());
    end

    // T4: shrunk raster, CLK_DIV=4: frame period and vsync width
    @(negedge clk);
    rst_c = 1'b0;
    #1;
    kc = 0; fs_n = 0; fs1 = -1; fs2 = -1; vs_low = 0;
    while (kc < 210) begin
      @(posedge clk); #1; kc++;
      if (ic.frame_start) begin
        fs_n++;
        if (fs1 < 0) fs1 = kc;
        else if (fs2 < 0) fs2 = kc;
      end
      if (!ic.vsync && fs1 >= 0 && fs2 < 0) vs_low++;
    end
    chk("T4 first frame_start", fs1, 4);
    chk("T4 frame period", fs2 - fs1, 200);
    chk("T4 frame_start pulses", fs_n, 2);
    chk("T4 vsync low clk", vs_low, 40);
    chk("T4 frame_count", int'(ic.frame_count), fce(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
